// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register file / write-back slice: default widths,
// ALU opcode constants used by decode and execute, and the register-address type.
package regfile_wb_pkg;

  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned RF_NUM_REGS = 16;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0100;
  localparam logic [3:0] OP_RS  = 4'b1000;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: tracks registers with an issued-but-unwritten result and
// raises a stall on RAW or WAW hazards against the presented instruction.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                write_en_i,
  input  logic [ADDR_W-1:0]   write_add_i,
  input  logic [ADDR_W-1:0]   read_add1_i,
  input  logic [ADDR_W-1:0]   read_add2_i,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_dest_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_mask_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hazard1, hazard2, waw;

  // A write landing this cycle resolves the pending result, so it does not block.
  always_comb begin
    hazard1 = busy_q[read_add1_i]  && !(write_en_i && (write_add_i == read_add1_i));
    hazard2 = busy_q[read_add2_i]  && !(write_en_i && (write_add_i == read_add2_i));
    waw     = busy_q[issue_dest_i] && !(write_en_i && (write_add_i == issue_dest_i));
    stall_o = issue_valid_i && (hazard1 || hazard2 || waw);
  end

  // Set is applied after clear so a new producer of the same register stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (write_en_i && (write_add_i != '0)) begin
      busy_d[write_add_i] = 1'b0;
    end
    if (issue_valid_i && !stall_o && (issue_dest_i != '0)) begin
      busy_d[issue_dest_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb.sv
// Register file and write-back endpoint: two combinational read ports with
// same-cycle write bypass, R0 hard-wired to zero, plus the issue scoreboard.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_write_en,
  input  logic [ADDR_W-1:0]   i_write_add,
  input  logic [DATA_W-1:0]   i_write_data,
  input  logic [ADDR_W-1:0]   i_read_add1,
  input  logic [ADDR_W-1:0]   i_read_add2,
  output logic [DATA_W-1:0]   o_read_data1,
  output logic [DATA_W-1:0]   o_read_data2,
  input  logic                i_issue_valid,
  input  logic [ADDR_W-1:0]   i_issue_dest,
  output logic                o_stall,
  output logic [NUM_REGS-1:0] o_busy_mask
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_fire;

  assign wr_fire = i_write_en && (i_write_add != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[i_write_add] <= i_write_data;
    end
  end

  always_comb begin
    o_read_data1 = mem_q[i_read_add1];
    if (wr_fire && (i_write_add == i_read_add1)) begin
      o_read_data1 = i_write_data;
    end
    if (i_read_add1 == '0) begin
      o_read_data1 = '0;
    end

    o_read_data2 = mem_q[i_read_add2];
    if (wr_fire && (i_write_add == i_read_add2)) begin
      o_read_data2 = i_write_data;
    end
    if (i_read_add2 == '0) begin
      o_read_data2 = '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk_i         (i_clk),
    .rst_ni        (i_reset),
    .write_en_i    (i_write_en),
    .write_add_i   (i_write_add),
    .read_add1_i   (i_read_add1),
    .read_add2_i   (i_read_add2),
    .issue_valid_i (i_issue_valid),
    .issue_dest_i  (i_issue_dest),
    .stall_o       (o_stall),
    .busy_mask_o   (o_busy_mask)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios then random traffic, checked by a
// queue-based scoreboard against an array model of registers and pending writes.
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_write_en;
  logic [AW-1:0] i_write_add;
  logic [DW-1:0] i_write_data;
  logic [AW-1:0] i_read_add1, i_read_add2;
  logic [DW-1:0] o_read_data1, o_read_data2;
  logic          i_issue_valid;
  logic [AW-1:0] i_issue_dest;
  logic          o_stall;
  logic [NR-1:0] o_busy_mask;

  regfile_wb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NR)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_write_en    (i_write_en),
    .i_write_add   (i_write_add),
    .i_write_data  (i_write_data),
    .i_read_add1   (i_read_add1),
    .i_read_add2   (i_read_add2),
    .o_read_data1  (o_read_data1),
    .o_read_data2  (o_read_data2),
    .i_issue_valid (i_issue_valid),
    .i_issue_dest  (i_issue_dest),
    .o_stall       (o_stall),
    .o_busy_mask   (o_busy_mask)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          stall;
    logic [NR-1:0] busy;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: register contents and the set of registers awaiting a result.
  logic [DW-1:0] m_regs [NR];
  logic          m_pending [NR];

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (i_write_en && i_write_add == a) return i_write_data;
    return m_regs[a];
  endfunction

  function automatic logic blocked(input logic [AW-1:0] a);
    return m_pending[a] && !(i_write_en && i_write_add == a);
  endfunction

  function automatic logic m_stall();
    return i_issue_valid &&
           (blocked(i_read_add1) || blocked(i_read_add2) || blocked(i_issue_dest));
  endfunction

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_pending[i];
    return m;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i]    = '0;
      m_pending[i] = 1'b0;
    end
  endtask

  task automatic expect_now(input string tag);
    exp_t e;
    e.rd1   = m_read(i_read_add1);
    e.rd2   = m_read(i_read_add2);
    e.stall = m_stall();
    e.busy  = m_mask();
    e.tag   = tag;
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                       input logic iv, input logic [AW-1:0] id);
    i_write_en    = we;
    i_write_add   = wa;
    i_write_data  = wd;
    i_read_add1   = ra1;
    i_read_add2   = ra2;
    i_issue_valid = iv;
    i_issue_dest  = id;
  endtask

  // Called at a negedge with inputs applied: check, then advance the model over the edge.
  task automatic step(input string tag);
    logic st;
    #1;
    expect_now(tag);
    @(posedge i_clk);
    if (i_reset) begin
      st = m_stall();
      if (i_write_en && i_write_add != 0) begin
        m_regs[i_write_add]    = i_write_data;
        m_pending[i_write_add] = 1'b0;
      end
      if (i_issue_valid && !st && i_issue_dest != 0) m_pending[i_issue_dest] = 1'b1;
    end
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
        e = exp_q.pop_front();
        check(e.tag, "read_data1", 32'(o_read_data1), 32'(e.rd1));
        check(e.tag, "read_data2", 32'(o_read_data2), 32'(e.rd2));
        check(e.tag, "stall",      32'(o_stall),      32'(e.stall));
        check(e.tag, "busy_mask",  32'(o_busy_mask),  32'(e.busy));
      end
    end
  end

  initial begin
    i_reset = 1'b0;
    drive(1'b0, '0, '0, 4'd3, 4'd15, 1'b0, '0);
    m_clear();
    @(negedge i_clk);
    step("reset");
    i_reset = 1'b1;

    drive(1'b1, 4'd5, 8'hA7, 4'd5, 4'd0, 1'b0, '0);
    step("bypass_w5");
    drive(1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0, '0);
    step("stored_r5");

    drive(1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b1, 4'd0);
    step("r0_write_issue");
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd5, 1'b1, 4'd0);
    step("r0_read");

    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1, 4'd4);
    step("issue4");
    drive(1'b0, 4'd0, 8'h00, 4'd4, 4'd0, 1'b1, 4'd1);
    step("raw_stall");
    drive(1'b1, 4'd4, 8'h12, 4'd4, 4'd0, 1'b1, 4'd1);
    step("raw_resolved");
    drive(1'b1, 4'd1, 8'h5C, 4'd4, 4'd1, 1'b0, '0);
    step("busy4_cleared");

    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1, 4'd6);
    step("issue6");
    drive(1'b1, 4'd6, 8'h66, 4'd0, 4'd0, 1'b1, 4'd6);
    step("set_wins");
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1, 4'd6);
    step("waw_stall");
    drive(1'b1, 4'd6, 8'h77, 4'd6, 4'd6, 1'b0, '0);
    step("clear6");

    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1, 4'd2);
    step("issue2");
    drive(1'b1, 4'd9, 8'h33, 4'd0, 4'd0, 1'b0, '0);
    step("write9");
    drive(1'b0, 4'd0, 8'h00, 4'd9, 4'd2, 1'b0, '0);
    #2;
    i_reset = 1'b0;
    #1;
    m_clear();
    expect_now("async_reset");
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    step("after_reset");

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
      step("random");
    end

    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
